// File: rtl/status_code_arbiter.sv
// Round-robin arbiter sharing one status-code processor among NUM requesters, one transaction in flight.
// Optional WAIT_RSP watchdog enabled by defining STATUS_ARB_TIMEOUT_EN.
module status_code_arbiter #(
  parameter int NUM         = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [NUM-1:0]   req_vld,
  input  logic [NUM*8-1:0] req_code,
  output logic [NUM-1:0]   req_rdy,
  output logic [NUM-1:0]   rsp_vld,
  output logic [15:0]      rsp_pl,
  output logic             proc_vld,
  output logic [7:0]       proc_code,
  input  logic             proc_rdy,
  input  logic             proc_rsp_vld,
  input  logic [15:0]      proc_rsp_pl,
  output logic             busy,
  output logic [IDW-1:0]   grant_id,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RETURN} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] last_reg, grant_reg;
  logic [IDW-1:0] winner, cand;
  logic           found;
  logic [7:0]     code_reg;
  logic [15:0]    pl_reg;
  logic [7:0]     code_arr [NUM];
  logic           expire;
  logic           to_flag;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_code
    assign code_arr[gi] = req_code[gi*8 +: 8];
  end

  // Search starts just after the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM; k++) begin
      cand = IDW'((int'(last_reg) + k) % NUM);
      if (!found && req_vld[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_rdy     = '0;
    rsp_vld     = '0;
    rsp_pl      = '0;
    proc_vld    = 1'b0;
    timeout_err = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          req_rdy[winner] = 1'b1;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        proc_vld = 1'b1;
        if (proc_rdy) state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (proc_rsp_vld || expire) state_next = RETURN;
      end
      RETURN: begin
        rsp_vld[grant_reg] = 1'b1;
        rsp_pl             = pl_reg;
        timeout_err        = to_flag;
        state_next         = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_reg;
  assign proc_code = code_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= IDW'(NUM - 1);
      grant_reg <= '0;
      code_reg  <= '0;
      pl_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && found) begin
        code_reg  <= code_arr[winner];
        last_reg  <= winner;
        grant_reg <= winner;
      end
      if (state_reg == WAIT_RSP) begin
        if (proc_rsp_vld)  pl_reg <= proc_rsp_pl;
        else if (expire)   pl_reg <= 16'hDEAD;
      end
    end
  end

`ifdef STATUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_reg;
  logic          err_reg;

  // A payload arriving on the expiry cycle takes precedence over the watchdog.
  assign expire  = (state_reg == WAIT_RSP) && (cnt_reg == CW'(TIMEOUT_CYC - 1)) && !proc_rsp_vld;
  assign to_flag = err_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == WAIT_RSP) cnt_reg <= cnt_reg + 1'b1;
      else                       cnt_reg <= '0;
      err_reg <= expire;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign expire         = 1'b0;
  assign to_flag        = 1'b0;
`endif

endmodule

// File: tb/tb_status_code_arbiter.sv
// Self-checking bench for status_code_arbiter: directed steps plus randomized transactions
// compared against a round-robin reference model.
module tb_status_code_arbiter;

  localparam int NUM = 4;
  localparam int IDW = 2;
  localparam int TO  = 8;
`ifdef STATUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             rst_n;
  logic [NUM-1:0]   req_vld;
  logic [NUM*8-1:0] req_code;
  logic [NUM-1:0]   req_rdy;
  logic [NUM-1:0]   rsp_vld;
  logic [15:0]      rsp_pl;
  logic             proc_vld;
  logic [7:0]       proc_code;
  logic             proc_rdy;
  logic             proc_rsp_vld;
  logic [15:0]      proc_rsp_pl;
  logic             busy;
  logic [IDW-1:0]   grant_id;
  logic             timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: last granted requester and visible grant index.
  int m_last = NUM - 1;
  int m_gid  = 0;

  status_code_arbiter #(.NUM(NUM), .IDW(IDW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .rst_n(rst_n), .req_vld(req_vld), .req_code(req_code), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_pl(rsp_pl), .proc_vld(proc_vld), .proc_code(proc_code),
    .proc_rdy(proc_rdy), .proc_rsp_vld(proc_rsp_vld), .proc_rsp_pl(proc_rsp_pl),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_winner(input logic [NUM-1:0] vld);
    for (int k = 1; k <= NUM; k++)
      if (vld[(m_last + k) % NUM]) return (m_last + k) % NUM;
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One full transaction starting from an IDLE cycle; rsp_at = WAIT_RSP cycle carrying the payload (0 = never).
  task automatic run_txn(input logic [NUM-1:0] vld, input logic [31:0] codes,
                         input int rdy_delay, input int rsp_at, input logic [15:0] pl);
    int          w;
    logic [7:0]  exp_code;
    logic [15:0] exp_pl;
    logic        exp_to;
    int          c;
    w        = model_winner(vld);
    exp_code = codes[w*8 +: 8];
    req_vld  = vld;
    req_code = codes;
    #1;
    check("idle_req_rdy", req_rdy, 32'(1) << w);
    check("idle_busy", busy, 0);
    check("idle_grant_id", grant_id, m_gid);
    step();
    m_last = w;
    m_gid  = w;
    for (int i = 0; i <= rdy_delay; i++) begin
      check("issue_proc_vld", proc_vld, 1);
      check("issue_proc_code", proc_code, exp_code);
      check("issue_req_rdy", req_rdy, 0);
      check("issue_busy", busy, 1);
      check("issue_rsp_vld", rsp_vld, 0);
      check("issue_grant_id", grant_id, w);
      proc_rsp_vld = 1'($urandom_range(0, 1));
      proc_rsp_pl  = 16'hBAD0;
      proc_rdy     = (i == rdy_delay);
      step();
    end
    proc_rdy     = 1'b0;
    proc_rsp_vld = 1'b0;
    exp_pl       = pl;
    exp_to       = 1'b0;
    c            = 1;
    while (1) begin
      check("wait_rsp_vld", rsp_vld, 0);
      check("wait_proc_vld", proc_vld, 0);
      check("wait_busy", busy, 1);
      proc_rsp_vld = (c == rsp_at);
      proc_rsp_pl  = pl;
      if (c == rsp_at) break;
      if (TO_EN && c == TO) begin
        exp_pl = 16'hDEAD;
        exp_to = 1'b1;
        break;
      end
      if (c > 40) begin
        check("wait_bound", c, 0);
        break;
      end
      c++;
      step();
    end
    step();
    proc_rsp_vld = 1'b0;
    req_vld      = '0;
    check("ret_rsp_vld", rsp_vld, 32'(1) << w);
    check("ret_rsp_pl", rsp_pl, exp_pl);
    check("ret_timeout_err", timeout_err, exp_to);
    $display("txn vld=%b winner=%0d code=%02h rsp_pl=%04h timeout=%0b", vld, w, exp_code, exp_pl, exp_to);
    // A stray payload pulse while IDLE must not produce a response.
    proc_rsp_vld = 1'($urandom_range(0, 1));
    step();
    check("post_rsp_vld", rsp_vld, 0);
    check("post_busy", busy, 0);
    check("post_timeout_err", timeout_err, 0);
    proc_rsp_vld = 1'b0;
  endtask

  initial begin
    int w;
    logic [NUM-1:0] vld;
    rst_n        = 1'b0;
    req_vld      = '0;
    req_code     = '0;
    proc_rdy     = 1'b0;
    proc_rsp_vld = 1'b0;
    proc_rsp_pl  = '0;
    repeat (2) @(negedge clock);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_pl", rsp_pl, 0);
    check("rst_proc_vld", proc_vld, 0);
    check("rst_proc_code", proc_code, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    step();

    // Minimum-latency single transaction.
    run_txn(4'b0001, 32'h0000_0043, 0, 1, 16'h1234);
    // Processor stalls 5 cycles while other requesters are pending.
    run_txn(4'b1110, 32'h5566_7788, 5, 2, 16'hA5A5);

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      do vld = NUM'($urandom); while (vld == 0);
      run_txn(vld, $urandom, $urandom_range(0, 3), $urandom_range(1, 4), 16'($urandom));
    end

    // Request withdrawn before the clock edge: no grant, pointer unchanged.
    req_vld = 4'b1000;
    #1;
    w = model_winner(4'b1000);
    check("drop_req_rdy", req_rdy, 32'(1) << w);
    req_vld = '0;
    step();
    check("drop_busy", busy, 0);
    check("drop_grant_id", grant_id, m_gid);

    // Reset while waiting for the payload, then a late payload.
    req_vld  = 4'b0110;
    req_code = 32'h0011_2233;
    step();
    req_vld  = '0;
    proc_rdy = 1'b1;
    step();
    proc_rdy = 1'b0;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_proc_vld", proc_vld, 0);
    check("mid_rst_proc_code", proc_code, 0);
    check("mid_rst_grant_id", grant_id, 0);
    proc_rsp_vld = 1'b1;
    proc_rsp_pl  = 16'h7777;
    step();
    check("mid_rst_rsp_vld", rsp_vld, 0);
    rst_n = 1'b1;
    step();
    check("late_rsp_vld", rsp_vld, 0);
    check("late_busy", busy, 0);
    proc_rsp_vld = 1'b0;
    m_last = NUM - 1;
    m_gid  = 0;

    // All requesters held: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 32'hD0C0_B0A0 + 32'(i), 0, 1, 16'(16'h0100 + i));
      check("rr_order", grant_id, i % NUM);
    end

`ifdef STATUS_ARB_TIMEOUT_EN
    run_txn(4'b0100, 32'h0099_0000, 1, 0, 16'h0000);
    run_txn(4'b0100, 32'h0099_0000, 0, TO, 16'h4242);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
